// File: rtl/seg_pkg.sv
// Shared types and the active-low segment table for the multiplexed
// 7-segment display driver.
package seg_pkg;

   typedef enum logic {BLANK, SHOW} scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; entry n is the pattern for hex digit n.
   localparam logic [15:0][6:0] SEG7_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG7_TABLE[hex_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed hex scanner: scan_clk edge stepping, blanking gap between
// digits, per-frame value snapshot and optional leading-zero suppression.
module seven_seg_scanner
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                    clk_in,
   input  logic                    reset,
   input  logic                    scan_clk,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [NUM_DIGITS-1:0]   anodes,
   output logic [6:0]              segments,
   output logic                    dp
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = $clog2(BLANK_CYCLES + 1);
   localparam int VW = 4 * NUM_DIGITS;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(BLANK_CYCLES - 1);
   localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

   logic sync1_q, sync2_q, prev_q;
   logic tick;

   scan_state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [VW-1:0]         snap_val_q, snap_val_d;
   logic [NUM_DIGITS-1:0] snap_en_q, snap_en_d;
   logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
   logic                  snap_lz_q, snap_lz_d;
   logic                  load;

   logic [3:0] nib;
   logic       sel_en, sel_dp, lz_hit, zero_hi, lit;
   logic [6:0] seg_w;

   logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;

   assign tick = sync2_q & ~prev_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (tick) begin
         idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
         state_d = BLANK;
         cnt_d   = '0;
      end else if (state_q == BLANK) begin
         if (cnt_q == LAST_CNT) begin
            state_d = SHOW;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Snapshot at the start of each frame so a digit never tears mid-scan.
   assign load       = (state_q == BLANK) && (idx_q == '0) && (cnt_q == '0);
   assign snap_val_d = load ? value    : snap_val_q;
   assign snap_en_d  = load ? digit_en : snap_en_q;
   assign snap_dp_d  = load ? dp_in    : snap_dp_q;
   assign snap_lz_d  = load ? blank_lz : snap_lz_q;

   always_comb begin
      nib     = 4'h0;
      sel_en  = 1'b0;
      sel_dp  = 1'b0;
      lz_hit  = 1'b0;
      zero_hi = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_hi = zero_hi & (snap_val_d[4*i +: 4] == 4'h0);
         if (idx_d == IW'(i)) begin
            nib    = snap_val_d[4*i +: 4];
            sel_en = snap_en_d[i];
            sel_dp = snap_dp_d[i];
            lz_hit = (i > 0) && zero_hi;
         end
      end
   end

   hex_to_seg7 u_hex (
      .hex_i (nib),
      .seg_o (seg_w)
   );

   assign lit      = (state_d == SHOW) && sel_en && !(snap_lz_d && lz_hit);
   assign anodes_d = lit ? ~(ONE_HOT0 << idx_d) : '1;
   assign seg_d    = lit ? seg_w : SEG_OFF;
   assign dp_d     = lit ? ~sel_dp : 1'b1;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         prev_q     <= 1'b0;
         state_q    <= BLANK;
         idx_q      <= '0;
         cnt_q      <= '0;
         snap_val_q <= '0;
         snap_en_q  <= '0;
         snap_dp_q  <= '0;
         snap_lz_q  <= 1'b0;
         anodes_q   <= '1;
         seg_q      <= SEG_OFF;
         dp_q       <= 1'b1;
      end else begin
         sync1_q    <= scan_clk;
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         snap_val_q <= snap_val_d;
         snap_en_q  <= snap_en_d;
         snap_dp_q  <= snap_dp_d;
         snap_lz_q  <= snap_lz_d;
         anodes_q   <= anodes_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign anodes   = anodes_q;
   assign segments = seg_q;
   assign dp       = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a digit/age reference model.
module tb_seven_seg_scanner;

   localparam int ND = 4;
   localparam int BC = 4;

   logic          clk_in = 1'b0;
   logic          reset;
   logic          scan_clk;
   logic [15:0]   value;
   logic [ND-1:0] digit_en;
   logic [ND-1:0] dp_in;
   logic          blank_lz;
   logic [ND-1:0] anodes;
   logic [6:0]    segments;
   logic          dp;

   seven_seg_scanner #(
      .NUM_DIGITS   (ND),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .scan_clk (scan_clk),
      .value    (value),
      .digit_en (digit_en),
      .dp_in    (dp_in),
      .blank_lz (blank_lz),
      .anodes   (anodes),
      .segments (segments),
      .dp       (dp)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int fails  = 0;

   logic [6:0] seg_tab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Model: current digit, edges since last step, frame snapshot,
   // and the last three sampled scan_clk levels (h[0] newest).
   int            m_d;
   int            m_age;
   logic [15:0]   m_val;
   logic [ND-1:0] m_en, m_dp;
   logic          m_lz;
   logic [2:0]    h;
   logic [ND-1:0] exp_an;
   logic [6:0]    exp_seg;
   logic          exp_dp;

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         if (fails <= 30)
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      logic        tk, lit, lz;
      logic [15:0] upper;
      tk = h[1] & ~h[2];
      if (reset) begin
         m_d = 0; m_age = 0; m_val = '0; m_en = '0; m_dp = '0;
         m_lz = 1'b0; h = '0;
      end else begin
         if (m_d == 0 && m_age == 0) begin
            m_val = value; m_en = digit_en; m_dp = dp_in; m_lz = blank_lz;
         end
         if (tk) begin
            m_d   = (m_d + 1) % ND;
            m_age = 0;
         end else if (m_age < BC) begin
            m_age++;
         end
         h = {h[1:0], scan_clk};
      end
      upper = m_val >> (4 * m_d);
      lz    = m_lz && (m_d > 0) && (upper == 16'h0);
      lit   = !reset && (m_age >= BC) && m_en[m_d] && !lz;
      exp_an  = lit ? ~(4'b0001 << m_d) : 4'hF;
      exp_seg = lit ? seg_tab[upper[3:0]] : 7'h7F;
      exp_dp  = lit ? ~m_dp[m_d] : 1'b1;
   endtask

   initial begin
      int ph;
      ph = 0;
      h = '0;
      m_d = 0; m_age = 0; m_val = '0; m_en = '0; m_dp = '0; m_lz = 1'b0;
      reset    = 1'b1;
      scan_clk = 1'b0;
      value    = 16'h1234;
      digit_en = 4'hF;
      dp_in    = 4'h0;
      blank_lz = 1'b0;

      for (int cyc = 0; cyc < 8000; cyc++) begin
         @(posedge clk_in);
         model_step();
         @(negedge clk_in);
         check("anodes", 16'(anodes), 16'(exp_an));
         check("segments", 16'(segments), 16'(exp_seg));
         check("dp", 16'(dp), 16'(exp_dp));
         if (cyc == 4) begin
            check("rst_anodes", 16'(anodes), 16'h000F);
            check("rst_segments", 16'(segments), 16'h007F);
            check("rst_dp", 16'(dp), 16'h0001);
         end
         if (cyc == 7)
            check("gap_anodes", 16'(anodes), 16'h000F);
         if (cyc == 8) begin
            check("first_anodes", 16'(anodes), 16'h000E);
            check("first_segments", 16'(segments), 16'h0019);
         end

         if (cyc == 4)
            reset = 1'b0;
         if (cyc >= 40) begin
            reset = ($urandom_range(0, 999) == 0);
            ph = (ph + 1) % 40;
            if (ph >= 22 && ph < 36 && $urandom_range(0, 99) == 0)
               scan_clk = 1'b1;
            else
               scan_clk = (ph < 20);
            if ($urandom_range(0, 59) == 0) begin
               case ($urandom_range(0, 3))
                  0: value = 16'($urandom);
                  1: value = 16'($urandom) & 16'h00FF;
                  2: value = 16'($urandom) & 16'h000F;
                  default: value = 16'h0000;
               endcase
               digit_en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
               dp_in    = 4'($urandom);
               blank_lz = 1'($urandom);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
